lu_share_ctrl: RTL and testbench

Round-robin controller that shares one fixed-latency, pipelined bitwise logic unit among N requesters. The unit computes D = A ^ (A ^ B) = B and F = (A & B) | (~A & C), bitwise. The controller arbitrates requests and registers the chosen operands into the unit. It tracks each in-flight operation with a tag pipeline and returns the registered result to the originating requester. Each requester may have at most one operation outstanding.

---
 rtl/lu_share_ctrl.sv | 158 +++++++++++++++
 tb/tb_lu_share_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lu_share_ctrl
// Brief    : Round-robin sharing of one pipelined bitwise logic unit among
//            N requesters, with tag tracking and per-requester responses.
// Revision : 1.0
// ============================================================================
module lu_share_ctrl #(
   parameter int N   = 4,
   parameter int W   = 1,
   parameter int LAT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] a,
   input  logic [N*W-1:0] b,
   input  logic [N*W-1:0] c,
   output logic [N-1:0]   gnt,
   output logic           unit_vld,
   output logic [W-1:0]   unit_a,
   output logic [W-1:0]   unit_b,
   output logic [W-1:0]   unit_c,
   input  logic [W-1:0]   unit_d,
   input  logic [W-1:0]   unit_f,
   output logic [N-1:0]   rsp_valid,
   output logic [W-1:0]   rsp_d,
   output logic [W-1:0]   rsp_f,
   output logic           busy
);

   localparam int            PW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

   logic [PW-1:0]          ptr_q, ptr_d;
   logic [N-1:0]           out_q, out_d;
   logic                   vld_q, vld_d;
   logic [W-1:0]           a_q, a_d;
   logic [W-1:0]           b_q, b_d;
   logic [W-1:0]           c_q, c_d;
   logic [PW-1:0]          id_q, id_d;
   logic [LAT-1:0]         tag_vld_q;
   logic [LAT-1:0][PW-1:0] tag_id_q;
   logic [N-1:0]           rsp_valid_q, rsp_valid_d;
   logic [W-1:0]           rsp_d_q, rsp_d_d;
   logic [W-1:0]           rsp_f_q, rsp_f_d;
   logic                   busy_q, busy_d;

   logic [N-1:0]           elig;
   logic                   gnt_any;
   logic [PW-1:0]          gnt_idx;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % N;
      return s[PW-1:0];
   endfunction

   assign elig = req & ~out_q;

   // Round-robin search starting at ptr; reset masks the grant entirely.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = ptr_q;
      for (int k = 0; k < N; k++) begin
         if (!gnt_any && elig[wrap_idx(ptr_q, k)]) begin
            gnt_any = 1'b1;
            gnt_idx = wrap_idx(ptr_q, k);
         end
      end
      if (rst) begin
         gnt_any = 1'b0;
      end
   end

   assign gnt = gnt_any ? (N'(1) << gnt_idx) : '0;

   always_comb begin
      ptr_d       = ptr_q;
      vld_d       = gnt_any;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      id_d        = id_q;
      // A slot is never set and cleared in the same cycle, so the order is moot.
      out_d       = (out_q & ~rsp_valid_q) | gnt;
      rsp_valid_d = '0;
      rsp_d_d     = rsp_d_q;
      rsp_f_d     = rsp_f_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
         a_d   = a[gnt_idx*W +: W];
         b_d   = b[gnt_idx*W +: W];
         c_d   = c[gnt_idx*W +: W];
         id_d  = gnt_idx;
      end
      if (tag_vld_q[LAT-1]) begin
         rsp_valid_d = N'(1) << tag_id_q[LAT-1];
         rsp_d_d     = unit_d;
         rsp_f_d     = unit_f;
      end
      busy_d = |out_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         out_q       <= '0;
         vld_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= '0;
         rsp_d_q     <= '0;
         rsp_f_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_q       <= out_d;
         vld_q       <= vld_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_d_q     <= rsp_d_d;
         rsp_f_q     <= rsp_f_d;
         busy_q      <= busy_d;
      end
   end

   // Tag pipeline: the last stage lines up with the unit's result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         tag_vld_q[0] <= vld_q;
         tag_id_q[0]  <= id_q;
         for (int s = 1; s < LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end
      end
   end

   assign unit_vld  = vld_q;
   assign unit_a    = a_q;
   assign unit_b    = b_q;
   assign unit_c    = c_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_d     = rsp_d_q;
   assign rsp_f     = rsp_f_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_share_ctrl
// Brief    : Directed self-checking bench for lu_share_ctrl (N=4, W=4, LAT=2).
// Revision : 1.0
// ============================================================================
module tb_lu_share_ctrl;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int LAT = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a, b, c;
   logic [N-1:0]   gnt;
   logic           unit_vld;
   logic [W-1:0]   unit_a, unit_b, unit_c, unit_d, unit_f;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_d, rsp_f;
   logic           busy;

   int errors = 0;
   int checks = 0;

   lu_share_ctrl #(.N(N), .W(W), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .gnt(gnt),
      .unit_vld(unit_vld), .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
      .unit_d(unit_d), .unit_f(unit_f), .rsp_valid(rsp_valid),
      .rsp_d(rsp_d), .rsp_f(rsp_f), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared logic unit: D = B, F = (A & B) | (~A & C), LAT cycles of delay.
   logic [LAT-1:0][W-1:0] ud_q, uf_q;
   always @(posedge clk) begin
      ud_q[0] <= unit_a ^ (unit_a ^ unit_b);
      uf_q[0] <= (unit_a & unit_b) | (~unit_a & unit_c);
      for (int s = 1; s < LAT; s++) begin
         ud_q[s] <= ud_q[s-1];
         uf_q[s] <= uf_q[s-1];
      end
   end
   assign unit_d = ud_q[LAT-1];
   assign unit_f = uf_q[LAT-1];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; a = '0; b = '0; c = '0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '1; a = '1; b = '1; c = '1;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      next_cycle();
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt2: got %b expected 0000", gnt); end
      checks++; if (unit_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", unit_vld); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp: got %b expected 0000", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({unit_a, unit_b, unit_c} !== 12'h000) begin errors++; $display("FAIL reset_ops: got %h expected 000", {unit_a, unit_b, unit_c}); end
      checks++; if ({rsp_d, rsp_f} !== 8'h00) begin errors++; $display("FAIL reset_rspdata: got %h expected 00", {rsp_d, rsp_f}); end
      next_cycle();
      rst = 1'b0; req = '0;
   endtask

   task automatic test_single();
      logic [N-1:0] exp_g [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic         exp_v [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [N-1:0] exp_r [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      logic         exp_b [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      req = 4'b0001; a = 16'h0001; b = 16'h0000; c = 16'h0001;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         checks++; if (gnt !== exp_g[cyc]) begin errors++; $display("FAIL single_gnt c%0d: got %b expected %b", cyc, gnt, exp_g[cyc]); end
         checks++; if (unit_vld !== exp_v[cyc]) begin errors++; $display("FAIL single_vld c%0d: got %b expected %b", cyc, unit_vld, exp_v[cyc]); end
         checks++; if (rsp_valid !== exp_r[cyc]) begin errors++; $display("FAIL single_rsp c%0d: got %b expected %b", cyc, rsp_valid, exp_r[cyc]); end
         checks++; if (busy !== exp_b[cyc]) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", cyc, busy, exp_b[cyc]); end
         if (cyc == 1) begin
            checks++; if ({unit_a, unit_b, unit_c} !== 12'h101) begin errors++; $display("FAIL single_ops: got %h expected 101", {unit_a, unit_b, unit_c}); end
         end
         if (cyc == 4) begin
            checks++; if ({rsp_d, rsp_f} !== 8'h00) begin errors++; $display("FAIL single_data: got %h expected 00", {rsp_d, rsp_f}); end
         end
         next_cycle();
         req = '0;
      end
   endtask

   task automatic test_all_requesters();
      logic [N-1:0] exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
      logic [N-1:0] exp_r [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [W-1:0] exp_d [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
      logic [W-1:0] exp_f [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h9, 4'hA, 4'hB};
      do_reset();
      req = 4'b1111; a = 16'h0000; b = 16'h4321; c = 16'hBA98;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         checks++; if (gnt !== exp_g[cyc]) begin errors++; $display("FAIL all_gnt c%0d: got %b expected %b", cyc, gnt, exp_g[cyc]); end
         checks++; if (rsp_valid !== exp_r[cyc]) begin errors++; $display("FAIL all_rsp c%0d: got %b expected %b", cyc, rsp_valid, exp_r[cyc]); end
         if (cyc >= 4) begin
            checks++; if (rsp_d !== exp_d[cyc]) begin errors++; $display("FAIL all_d c%0d: got %h expected %h", cyc, rsp_d, exp_d[cyc]); end
            checks++; if (rsp_f !== exp_f[cyc]) begin errors++; $display("FAIL all_f c%0d: got %h expected %h", cyc, rsp_f, exp_f[cyc]); end
         end
         next_cycle();
      end
      req = '0;
   endtask

   task automatic test_fairness();
      do_reset();
      req = 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL fair_setup: got %b expected 0001", gnt); end
      next_cycle();
      req = '0;
      repeat (4) next_cycle();
      req = 4'b1001;
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL fair_first: got %b expected 1000", gnt); end
      next_cycle();
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL fair_second: got %b expected 0001", gnt); end
      next_cycle();
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_none: got %b expected 0000", gnt); end
      next_cycle();
      req = '0;
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL fair_rsp3: got %b expected 1000", rsp_valid); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL fair_rsp0: got %b expected 0001", rsp_valid); end
      next_cycle();
      req = 4'b0011;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fair_ptr: got %b expected 0010", gnt); end
      next_cycle();
      req = '0;
   endtask

   task automatic test_values();
      do_reset();
      req = 4'b0001; a = 16'h000C; b = 16'h000A; c = 16'h0006;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL val_gnt0: got %b expected 0001", gnt); end
      next_cycle();
      req = 4'b0010; a = 16'h0000; b = 16'h00F0; c = 16'h0050;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL val_gnt1: got %b expected 0010", gnt); end
      next_cycle();
      req = '0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL val_rsp0: got %b expected 0001", rsp_valid); end
      checks++; if ({rsp_d, rsp_f} !== 8'hAA) begin errors++; $display("FAIL val_data0: got %h expected AA", {rsp_d, rsp_f}); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL val_rsp1: got %b expected 0010", rsp_valid); end
      checks++; if ({rsp_d, rsp_f} !== 8'hF5) begin errors++; $display("FAIL val_data1: got %h expected F5", {rsp_d, rsp_f}); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL val_idle: got %b expected 0000", rsp_valid); end
      checks++; if ({rsp_d, rsp_f} !== 8'hF5) begin errors++; $display("FAIL val_hold: got %h expected F5", {rsp_d, rsp_f}); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0011; a = 16'h0033; b = 16'h0055; c = 16'h0077;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt0: got %b expected 0001", gnt); end
      next_cycle();
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt1: got %b expected 0010", gnt); end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rstgnt: got %b expected 0000", gnt); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp c2: got %b expected 0000", rsp_valid); end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (unit_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b expected 0", unit_vld); end
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_regnt: got %b expected 0001", gnt); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp c3: got %b expected 0000", rsp_valid); end
      next_cycle();
      req = '0;
      for (int cyc = 4; cyc < 8; cyc++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== ((cyc == 7) ? 4'b0001 : 4'b0000)) begin
            errors++; $display("FAIL mid_rsp c%0d: got %b expected %b", cyc, rsp_valid, (cyc == 7) ? 4'b0001 : 4'b0000);
         end
         next_cycle();
      end
   endtask

   task automatic test_rerequest();
      do_reset();
      req = 4'b0100; a = 16'h0000; b = 16'h0000; c = 16'h0000;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         checks++;
         if (gnt !== ((cyc == 0 || cyc == 5) ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL rereq_gnt c%0d: got %b expected %b", cyc, gnt, (cyc == 0 || cyc == 5) ? 4'b0100 : 4'b0000);
         end
         next_cycle();
      end
      req = '0;
   endtask

   initial begin
      rst = 1'b1; req = '0; a = '0; b = '0; c = '0;
      test_reset();
      test_single();
      test_all_requesters();
      test_fairness();
      test_values();
      test_reset_mid();
      test_rerequest();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
